sync_io_mc: RTL and testbench
=============================

Name: sync_io_mc

Overview:
Multi-channel successor of the single PPS in/out block in the RTC subsystem. It timestamps edges on NCH_IN external event inputs into per-channel FIFOs, read through a shared pop interface. It also generates NCH_OUT programmable periodic pulse outputs (PPS, PPX, xms interrupts) phase-aligned to RTC second boundaries. Sits beside the RTC counter and takes the free-running rtc_std/rtc_fns time and the current tick increment.

Parameters:
NCH_IN, 4, number of event-capture channels (1..8)
NCH_OUT, 2, number of periodic pulse outputs (1..4)
FIFO_DEPTH, 4, timestamp entries per capture channel (power of 2, >=2)
SYNC_STAGES, 2, input synchroniser flops (>=2)
FNS_W, 26, fractional-ns bits of tick_inc_i (tick_inc_i is 6.FNS_W unsigned ns)
CW, 2, channel-select width, clog2(NCH_IN) (min 1)

Ports:
rtc_clk  in  1  RTC clock
rtc_rst_n  in  1  async reset, active low
tick_inc_i  in  32  ns added per rtc_clk cycle, 6.FNS_W format
rtc_std_i  in  80  [79:32] seconds, [31:0] ns (0..999999999)
rtc_fns_i  in  16  fractional ns of RTC
evt_i  in  NCH_IN  asynchronous event inputs
evt_edge_sel_i  in  2*NCH_IN  per channel: 00 off, 01 rise, 10 fall, 11 both
rd_ch_i  in  CW  channel selected for read
rd_pop_i  in  1  pop head of selected FIFO
rd_valid_o  out  1  selected FIFO non-empty
rd_std_o  out  80  head timestamp sec+ns
rd_fns_o  out  16  head timestamp fractional ns
rd_rise_o  out  1  head entry edge: 1 rise, 0 fall
fifo_ne_o  out  NCH_IN  per-channel non-empty
fifo_ovf_o  out  NCH_IN  per-channel sticky overflow
ovf_clr_i  in  NCH_IN  clear overflow sticky
out_en_i  in  NCH_OUT  enable per pulse output
out_period_i  in  32*NCH_OUT  period in integer ns, must divide 10^9
out_width_i  in  32*NCH_OUT  high width in integer ns
pulse_o  out  NCH_OUT  periodic pulse outputs (registered)
pulse_start_o  out  NCH_OUT  one-cycle strobe at each pulse rising edge

Behaviour:
- Reset: rtc_rst_n async, active-low; clock rtc_clk. All flops cleared. pulse_o, pulse_start_o, fifo_ne_o, fifo_ovf_o, rd_valid_o = 0. rd_std_o/rd_fns_o/rd_rise_o = 0 while the selected FIFO is empty. Reset mid-operation discards all FIFO contents and accumulators.
- Capture: evt_i[k] passes SYNC_STAGES flops plus one history flop. Edge is detected when sync output differs from history and matches the edge_sel filter. On the detect cycle, {rtc_std_i, rtc_fns_i, rise} is pushed. Latency from input transition to push is SYNC_STAGES+1 cycles; software corrects. Edge select 00 suppresses detection only, not synchronisation.
- FIFO: per channel, FIFO_DEPTH entries, first-word fall-through. rd_valid_o = fifo_ne_o[rd_ch_i]; head data is a combinational mux. Pop with rd_valid_o=0 is ignored. rd_ch_i >= NCH_IN reads as empty.
- Full + push without pop: new event dropped, fifo_ovf_o[k] set. Full + push + pop on same channel: both happen, no overflow. ovf_clr_i clears the sticky; if a clear and a new overflow coincide, set wins.
- Second boundary: sec_chg = rtc_std_i[79:32] differs from its value one cycle earlier. This covers normal increment and software time jumps.
- Pulse output j, with per-channel accumulator acc (32+FNS_W bits):
  - Disabled (out_en_i[j]=0): pulse_o=0, acc=0, armed=0.
  - Enabled: waits for sec_chg, then arms.
  - On sec_chg: acc <= 0, pulse_o <= 1 (if enabled), pulse_start_o <= 1.
  - Otherwise acc_n = acc + tick_inc_i. If acc_n integer part >= period: acc <= acc_n - (period << FNS_W), pulse_o <= 1, strobe. The fraction is preserved, so there is no drift.
  - Else acc <= acc_n. pulse_o <= 0 once acc_n integer part >= width.
  - sec_chg takes priority over a period rollover in the same cycle. Rollover takes priority over width-end.
- Width/period sanitising (registered once per cycle):
  - period == 0: output held 0.
  - width == 0 or width >= period: effective width = period >> 1.
  - A period that does not divide 10^9 is not checked; the last partial period is truncated by sec_chg.
- Arithmetic is unsigned. Comparisons use the integer part acc[31+FNS_W:FNS_W].

Test Plan:
- Reset during capture, FIFO 3 entries deep: after release, fifo_ne_o=0 and rd_valid_o=0; 8 rising edges produce 4 entries; fifo_ovf_o[0]=1.
- tick_inc=0x20000000 (8 ns), rtc ns at detect = 500, edge_sel=01, evt_i[1] rises → after 3 cycles fifo_ne_o[1]=1; head ns=500, rd_rise_o=1; the fall is not captured.
- edge_sel=11 on ch2, pulse width 100 cycles → 2 entries, rise then fall, timestamps 800 ns apart. Pop both → rd_valid_o=0.
- Full ch0 with simultaneous push+pop → no overflow, 4 entries remain. ovf_clr_i and overflow in the same cycle → fifo_ovf_o stays 1.
- Period=10000000, width=0, tick 8 ns → pulse_o rises on the cycle after sec_chg, rises again every 1250000 cycles, and is high 625000 cycles. Gives 100 pulse_start_o per second.
- Tick 6.4 ns (0x19999999), period 1000000000, width 100 → one pulse per second of 16 cycles. Forced seconds jump mid-second → immediate resync pulse.

Source files
------------

// File: rtl/sync_io_mc.sv
// sync_io_mc: multi-channel RTC event timestamping and periodic pulse generation.
// Capture side: each event input is synchronised and edge-filtered. Each accepted
// edge pushes {rtc_std, rtc_fns, rise} into a per-channel first-word fall-through
// FIFO, and all channels are read through one shared pop port.
// Pulse side: each output runs a fractional-ns phase accumulator. The accumulator
// restarts on every RTC second change, so pulses stay phase-aligned to the second.
module sync_io_mc #(
  parameter int NCH_IN      = 4,
  parameter int NCH_OUT     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FNS_W       = 26,
  parameter int CW          = 2
) (
  input  logic                   rtc_clk,
  input  logic                   rtc_rst_n,
  input  logic [31:0]            tick_inc_i,
  input  logic [79:0]            rtc_std_i,
  input  logic [15:0]            rtc_fns_i,
  input  logic [NCH_IN-1:0]      evt_i,
  input  logic [2*NCH_IN-1:0]    evt_edge_sel_i,
  input  logic [CW-1:0]          rd_ch_i,
  input  logic                   rd_pop_i,
  output logic                   rd_valid_o,
  output logic [79:0]            rd_std_o,
  output logic [15:0]            rd_fns_o,
  output logic                   rd_rise_o,
  output logic [NCH_IN-1:0]      fifo_ne_o,
  output logic [NCH_IN-1:0]      fifo_ovf_o,
  input  logic [NCH_IN-1:0]      ovf_clr_i,
  input  logic [NCH_OUT-1:0]     out_en_i,
  input  logic [32*NCH_OUT-1:0]  out_period_i,
  input  logic [32*NCH_OUT-1:0]  out_width_i,
  output logic [NCH_OUT-1:0]     pulse_o,
  output logic [NCH_OUT-1:0]     pulse_start_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 80 + 16 + 1;
  localparam int ACC_W = 32 + FNS_W;

  // A zero width, or a width that would cover the whole period, falls back to 50% duty.
  function automatic logic [31:0] eff_width(input logic [31:0] period, input logic [31:0] width);
    if (width == 32'd0 || width >= period) return period >> 1;
    return width;
  endfunction

  // ---------------------------------------------------------------------------
  // Event capture
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q [NCH_IN];
  logic [NCH_IN-1:0]      hist_q;
  logic [NCH_IN-1:0]      sync_out;
  logic [NCH_IN-1:0]      det;

  // Synchroniser chain plus one history flop per channel; it runs even when the channel is filtered off.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int k = 0; k < NCH_IN; k++) sync_q[k] <= '0;
      hist_q <= '0;
    end else begin
      for (int k = 0; k < NCH_IN; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], evt_i[k]};
        hist_q[k] <= sync_q[k][SYNC_STAGES-1];
      end
    end
  end

  // Edge detection: sel bit 0 enables rising edges and sel bit 1 enables falling edges.
  always_comb begin
    sync_out = '0;
    det      = '0;
    for (int k = 0; k < NCH_IN; k++) begin
      sync_out[k] = sync_q[k][SYNC_STAGES-1];
      det[k]      = (sync_out[k] != hist_q[k]) &&
                    (sync_out[k] ? evt_edge_sel_i[2*k] : evt_edge_sel_i[2*k+1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel timestamp FIFOs
  // ---------------------------------------------------------------------------
  logic [EW-1:0]     mem_q    [NCH_IN][FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q [NCH_IN];
  logic [AW:0]       rd_ptr_q [NCH_IN];
  logic [NCH_IN-1:0] empty, full, pop, push, ovf_set, ovf_q;
  logic [EW-1:0]     head;

  // FIFO status and handshake decode. A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
  always_comb begin
    empty   = '0;
    full    = '0;
    pop     = '0;
    push    = '0;
    ovf_set = '0;
    for (int k = 0; k < NCH_IN; k++) begin
      empty[k]   = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]    = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                   (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
      pop[k]     = rd_pop_i && (int'(rd_ch_i) == k) && !empty[k];
      push[k]    = det[k] && (!full[k] || pop[k]);
      ovf_set[k] = det[k] && full[k] && !pop[k];
    end
  end

  // FIFO storage, pointers and the sticky overflow flag; a new overflow wins over a clear.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int k = 0; k < NCH_IN; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) mem_q[k][d] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NCH_IN; k++) begin
        if (push[k]) begin
          mem_q[k][wr_ptr_q[k][AW-1:0]] <= {rtc_std_i, rtc_fns_i, sync_out[k]};
          wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        end
        if (pop[k]) rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        ovf_q[k] <= ovf_set[k] | (ovf_q[k] & ~ovf_clr_i[k]);
      end
    end
  end

  // Shared read port: fall-through head of the selected channel; it reads as all zeros when that channel is empty or out of range.
  always_comb begin
    head       = '0;
    rd_valid_o = 1'b0;
    for (int k = 0; k < NCH_IN; k++) begin
      if ((int'(rd_ch_i) == k) && !empty[k]) begin
        head       = mem_q[k][rd_ptr_q[k][AW-1:0]];
        rd_valid_o = 1'b1;
      end
    end
    rd_std_o  = head[EW-1:17];
    rd_fns_o  = head[16:1];
    rd_rise_o = head[0];
  end

  assign fifo_ne_o  = ~empty;
  assign fifo_ovf_o = ovf_q;

  // ---------------------------------------------------------------------------
  // Periodic pulse outputs
  // ---------------------------------------------------------------------------
  logic [31:0]        per_p0 [NCH_OUT];
  logic [31:0]        wid_p0 [NCH_OUT];
  logic [47:0]        sec_p0;
  logic               sec_vld_p0;
  logic               sec_chg;
  logic [ACC_W-1:0]   acc_q  [NCH_OUT];
  logic [ACC_W-1:0]   acc_n  [NCH_OUT];
  logic [31:0]        acc_int[NCH_OUT];
  logic [NCH_OUT-1:0] armed_q, pulse_q, start_q;

  // Register the sanitised period/width and the previous seconds value. The valid flag stops the first sample after reset from counting as a second change.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int j = 0; j < NCH_OUT; j++) begin
        per_p0[j] <= '0;
        wid_p0[j] <= '0;
      end
      sec_p0     <= '0;
      sec_vld_p0 <= 1'b0;
    end else begin
      for (int j = 0; j < NCH_OUT; j++) begin
        per_p0[j] <= out_period_i[32*j +: 32];
        wid_p0[j] <= eff_width(out_period_i[32*j +: 32], out_width_i[32*j +: 32]);
      end
      sec_p0     <= rtc_std_i[79:32];
      sec_vld_p0 <= 1'b1;
    end
  end

  // Second-change detect and next accumulator value; a jump in the seconds field also counts as a change.
  always_comb begin
    sec_chg = sec_vld_p0 && (rtc_std_i[79:32] != sec_p0);
    for (int j = 0; j < NCH_OUT; j++) begin
      acc_n[j]   = acc_q[j] + ACC_W'(tick_inc_i);
      acc_int[j] = acc_n[j][ACC_W-1:FNS_W];
    end
  end

  // Pulse engine. Priority: disable, then second change, then period rollover (which keeps the fraction), then width end.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int j = 0; j < NCH_OUT; j++) acc_q[j] <= '0;
      armed_q <= '0;
      pulse_q <= '0;
      start_q <= '0;
    end else begin
      for (int j = 0; j < NCH_OUT; j++) begin
        start_q[j] <= 1'b0;
        if (!out_en_i[j] || per_p0[j] == 32'd0) begin
          acc_q[j]   <= '0;
          armed_q[j] <= 1'b0;
          pulse_q[j] <= 1'b0;
        end else if (sec_chg) begin
          acc_q[j]   <= '0;
          armed_q[j] <= 1'b1;
          pulse_q[j] <= 1'b1;
          start_q[j] <= 1'b1;
        end else if (armed_q[j]) begin
          if (acc_int[j] >= per_p0[j]) begin
            acc_q[j]   <= acc_n[j] - {per_p0[j], {FNS_W{1'b0}}};
            pulse_q[j] <= 1'b1;
            start_q[j] <= 1'b1;
          end else begin
            acc_q[j] <= acc_n[j];
            if (acc_int[j] >= wid_p0[j]) pulse_q[j] <= 1'b0;
          end
        end
      end
    end
  end

  assign pulse_o       = pulse_q;
  assign pulse_start_o = start_q;

endmodule

// File: tb/tb_sync_io_mc.sv
// Testbench for sync_io_mc: a table-driven FIFO/overflow sequence on channel 0,
// followed by hand-written capture and pulse-generation sequences.
module tb_sync_io_mc;

  logic         rtc_clk = 1'b0;
  logic         rtc_rst_n;
  logic [31:0]  tick_inc;
  logic [47:0]  rtc_sec;
  logic [31:0]  rtc_ns;
  logic [79:0]  rtc_std;
  logic [15:0]  rtc_fns;
  logic [3:0]   evt;
  logic [7:0]   edge_sel;
  logic [1:0]   rd_ch;
  logic         rd_pop;
  logic         rd_valid;
  logic [79:0]  rd_std;
  logic [15:0]  rd_fns;
  logic         rd_rise;
  logic [3:0]   fifo_ne;
  logic [3:0]   fifo_ovf;
  logic [3:0]   ovf_clr;
  logic [1:0]   out_en;
  logic [63:0]  out_period;
  logic [63:0]  out_width;
  logic [1:0]   pulse;
  logic [1:0]   pstart;

  int checks   = 0;
  int failures = 0;

  assign rtc_std = {rtc_sec, rtc_ns};
  assign rtc_fns = rtc_ns[15:0] ^ 16'hA5A5;

  always #5 rtc_clk = ~rtc_clk;

  sync_io_mc dut (
    .rtc_clk        (rtc_clk),
    .rtc_rst_n      (rtc_rst_n),
    .tick_inc_i     (tick_inc),
    .rtc_std_i      (rtc_std),
    .rtc_fns_i      (rtc_fns),
    .evt_i          (evt),
    .evt_edge_sel_i (edge_sel),
    .rd_ch_i        (rd_ch),
    .rd_pop_i       (rd_pop),
    .rd_valid_o     (rd_valid),
    .rd_std_o       (rd_std),
    .rd_fns_o       (rd_fns),
    .rd_rise_o      (rd_rise),
    .fifo_ne_o      (fifo_ne),
    .fifo_ovf_o     (fifo_ovf),
    .ovf_clr_i      (ovf_clr),
    .out_en_i       (out_en),
    .out_period_i   (out_period),
    .out_width_i    (out_width),
    .pulse_o        (pulse),
    .pulse_start_o  (pstart)
  );

  typedef struct {
    logic       evt;
    logic       pop;
    logic       clr;
    logic [3:0] ne;
    logic       ovf;
    int         head;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t v(input int e, input int p, input int c, input int n, input int o, input int h);
    vec_t r;
    r.evt  = (e != 0);
    r.pop  = (p != 0);
    r.clr  = (c != 0);
    r.ne   = 4'(n);
    r.ovf  = (o != 0);
    r.head = h;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rtc_clk);
    #1;
    rtc_ns = rtc_ns + 32'd8;
  endtask

  task automatic pop_once();
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   base;
    int   n0;
    int   hns;
    logic p, s;

    rtc_rst_n  = 1'b0;
    tick_inc   = 32'h2000_0000;
    rtc_sec    = 48'd5;
    rtc_ns     = 32'd100;
    evt        = '0;
    edge_sel   = '0;
    rd_ch      = '0;
    rd_pop     = 1'b0;
    ovf_clr    = '0;
    out_en     = '0;
    out_period = '0;
    out_width  = '0;

    // Reset state
    repeat (2) step();
    chk("rst_ne", 96'(fifo_ne), 96'(0));
    chk("rst_ovf", 96'(fifo_ovf), 96'(0));
    chk("rst_valid", 96'(rd_valid), 96'(0));
    chk("rst_std", 96'(rd_std), 96'(0));
    chk("rst_pulse", 96'({pulse, pstart}), 96'(0));
    rtc_rst_n = 1'b1;
    repeat (2) step();

    // Load 3 entries into ch0, then apply reset in the middle of a cycle
    edge_sel = 8'b0000_0001;
    for (int i = 0; i < 3; i++) begin
      evt[0] = 1'b1; step();
      evt[0] = 1'b0; step();
    end
    repeat (3) step();
    chk("pre_rst_ne", 96'(fifo_ne), 96'(4'h1));
    #3 rtc_rst_n = 1'b0;
    #1;
    chk("async_rst_ne", 96'(fifo_ne), 96'(0));
    chk("async_rst_valid", 96'(rd_valid), 96'(0));
    step();
    rtc_rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_ne", 96'(fifo_ne), 96'(0));
    chk("post_rst_valid", 96'(rd_valid), 96'(0));
    chk("post_rst_std", 96'(rd_std), 96'(0));

    // Table: 8 rises fill/overflow ch0, clear, push+pop at full, clear-vs-set, drain
    tbl[0]  = v(1,0,0,0,0,-1);  tbl[1]  = v(0,0,0,0,0,-1);
    tbl[2]  = v(1,0,0,1,0,2);   tbl[3]  = v(0,0,0,1,0,2);
    tbl[4]  = v(1,0,0,1,0,2);   tbl[5]  = v(0,0,0,1,0,2);
    tbl[6]  = v(1,0,0,1,0,2);   tbl[7]  = v(0,0,0,1,0,2);
    tbl[8]  = v(1,0,0,1,0,2);   tbl[9]  = v(0,0,0,1,0,2);
    tbl[10] = v(1,0,0,1,1,2);   tbl[11] = v(0,0,0,1,1,2);
    tbl[12] = v(1,0,0,1,1,2);   tbl[13] = v(0,0,0,1,1,2);
    tbl[14] = v(1,0,0,1,1,2);   tbl[15] = v(0,0,0,1,1,2);
    tbl[16] = v(0,0,0,1,1,2);   tbl[17] = v(0,0,0,1,1,2);
    tbl[18] = v(0,0,1,1,0,2);   tbl[19] = v(1,0,0,1,0,2);
    tbl[20] = v(1,0,0,1,0,2);   tbl[21] = v(1,1,0,1,0,4);
    tbl[22] = v(0,0,0,1,0,4);   tbl[23] = v(1,0,0,1,0,4);
    tbl[24] = v(1,0,0,1,0,4);   tbl[25] = v(1,0,1,1,1,4);
    tbl[26] = v(1,0,0,1,1,4);   tbl[27] = v(1,1,0,1,1,6);
    tbl[28] = v(1,1,0,1,1,8);   tbl[29] = v(1,1,0,1,1,21);
    tbl[30] = v(1,1,0,0,1,-1);  tbl[31] = v(1,1,0,0,1,-1);
    tbl[32] = v(0,0,1,0,0,-1);

    rd_ch = 2'd0;
    base  = int'(rtc_ns);
    for (int r = 0; r < 33; r++) begin
      evt[0]     = tbl[r].evt;
      rd_pop     = tbl[r].pop;
      ovf_clr[0] = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_ne", r), 96'(fifo_ne), 96'(tbl[r].ne));
      chk($sformatf("tbl%0d_ovf", r), 96'(fifo_ovf), 96'({3'b000, tbl[r].ovf}));
      chk($sformatf("tbl%0d_valid", r), 96'(rd_valid), 96'(tbl[r].head >= 0));
      if (tbl[r].head >= 0) begin
        hns = base + 8 * tbl[r].head;
        chk($sformatf("tbl%0d_std", r), 96'(rd_std), 96'({rtc_sec, 32'(hns)}));
        chk($sformatf("tbl%0d_fns", r), 96'(rd_fns), 96'(16'(hns) ^ 16'hA5A5));
        chk($sformatf("tbl%0d_rise", r), 96'(rd_rise), 96'(1));
      end else begin
        chk($sformatf("tbl%0d_std0", r), 96'({rd_std, rd_fns, rd_rise}), 96'(0));
      end
    end
    rd_pop  = 1'b0;
    ovf_clr = '0;
    evt     = '0;
    repeat (4) step();

    // ch1 rise-only capture with a timestamp of 500 ns; the fall is filtered out
    rd_ch    = 2'd1;
    edge_sel = 8'b0000_0100;
    rtc_ns   = 32'd484;
    evt[1]   = 1'b1;
    step(); chk("ch1_lat1", 96'(fifo_ne[1]), 96'(0));
    step(); chk("ch1_lat2", 96'(fifo_ne[1]), 96'(0));
    step(); chk("ch1_lat3", 96'(fifo_ne[1]), 96'(1));
    chk("ch1_std", 96'(rd_std), 96'({rtc_sec, 32'd500}));
    chk("ch1_rise", 96'(rd_rise), 96'(1));
    repeat (3) step();
    evt[1] = 1'b0;
    repeat (6) step();
    chk("ch1_fall_ignored", 96'(fifo_ne), 96'(4'b0010));
    pop_once();
    chk("ch1_popped_valid", 96'(rd_valid), 96'(0));
    chk("ch1_popped_ne", 96'(fifo_ne), 96'(0));

    // ch2 both edges: a 100-cycle pulse gives entries 800 ns apart
    rd_ch    = 2'd2;
    edge_sel = 8'b0011_0000;
    n0       = int'(rtc_ns);
    evt[2]   = 1'b1;
    repeat (100) step();
    evt[2] = 1'b0;
    repeat (5) step();
    chk("ch2_ne", 96'(fifo_ne), 96'(4'b0100));
    chk("ch2_std_rise", 96'(rd_std), 96'({rtc_sec, 32'(n0 + 16)}));
    chk("ch2_rise", 96'(rd_rise), 96'(1));
    pop_once();
    chk("ch2_std_fall", 96'(rd_std), 96'({rtc_sec, 32'(n0 + 816)}));
    chk("ch2_fall", 96'(rd_rise), 96'(0));
    chk("ch2_valid2", 96'(rd_valid), 96'(1));
    pop_once();
    chk("ch2_empty", 96'(rd_valid), 96'(0));
    chk("ch2_ne_empty", 96'(fifo_ne), 96'(0));

    // Pulses: tick 8 ns, period 80; ch0 width 0 and ch1 width 200 both become 40
    tick_inc   = 32'h2000_0000;
    out_period = {32'd80, 32'd80};
    out_width  = {32'd200, 32'd0};
    out_en     = 2'b11;
    repeat (3) step();
    chk("pls_wait_arm", 96'({pulse, pstart}), 96'(0));
    rtc_sec = rtc_sec + 48'd1;
    for (int k = 0; k < 30; k++) begin
      step();
      p = ((k % 10) < 5);
      s = ((k % 10) == 0);
      chk($sformatf("pls8_%0d", k), 96'(pulse), 96'({p, p}));
      chk($sformatf("pstart8_%0d", k), 96'(pstart), 96'({s, s}));
    end
    out_en = 2'b10;
    step();
    chk("pls_disable", 96'(pulse), 96'(2'b10));
    out_en = 2'b11;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("pls_unarmed_%0d", k), 96'({pulse[0], pstart[0]}), 96'(0));
    end

    // Tick 6.4 ns, period 1 s, width 100: 16 cycles high; ch1 with period 0 stays low
    tick_inc   = 32'h1999_9999;
    out_period = {32'd0, 32'd1000000000};
    out_width  = {32'd10, 32'd100};
    repeat (3) step();
    rtc_sec = rtc_sec + 48'd1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("pps_%0d", k), 96'(pulse), 96'({1'b0, k < 16}));
      chk($sformatf("pps_start_%0d", k), 96'(pstart), 96'({1'b0, k == 0}));
    end
    rtc_sec = rtc_sec + 48'd7;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("jump_%0d", k), 96'(pulse), 96'({1'b0, k < 16}));
      chk($sformatf("jump_start_%0d", k), 96'(pstart), 96'({1'b0, k == 0}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
